// File: rtl/mem_port_bram_server.sv
// mem_port_bram_server: wait-stated, byte-lane-writable 32-bit block RAM behind a level-held request/ready handshake.
module mem_port_bram_server #(
  parameter int DEPTH_LOG2     = 10,
  parameter int WAIT_STATES    = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_logic,
  input  logic        reset,
  input  logic [20:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [3:0]  mem_byte_en,
  output logic [31:0] mem_q,
  output logic        mem_ready,
  output logic        init_done
);
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WAIT, S_ACCESS, S_DONE, S_RECOVER} state_t;
  localparam logic [DEPTH_LOG2-1:0] LAST = '1;
  state_t                r_state, w_next;
  logic [DEPTH_LOG2-1:0] r_clr;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [31:0]           r_data;
  logic [3:0]            r_be;
  logic                  r_wr;
  logic [31:0]           r_q;
  logic                  r_init;
  logic [31:0]           r_mem [0:2**DEPTH_LOG2-1];
  logic                  w_req;
  assign w_req     = mem_wr | mem_rd;
  assign mem_q     = r_q;
  assign mem_ready = (r_state == S_DONE);
  assign init_done = r_init;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR:   w_next = (r_clr == LAST) ? S_IDLE : S_CLEAR;
      S_IDLE:    w_next = !w_req ? S_IDLE : (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:    w_next = (r_cnt <= 4'd1) ? S_ACCESS : S_WAIT;
      S_ACCESS:  w_next = S_DONE;
      S_DONE:    w_next = S_RECOVER;
      S_RECOVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_clr   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_wr    <= 1'b0;
      r_q     <= '0;
      r_init  <= !CLEAR_ON_RESET;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR && r_clr != LAST) r_clr <= r_clr + DEPTH_LOG2'(1);
      if (r_state == S_CLEAR && r_clr == LAST) r_init <= 1'b1;
      if (r_state == S_IDLE && w_req) begin
        r_addr <= mem_addr[DEPTH_LOG2-1:0];
        r_data <= mem_data;
        r_be   <= mem_byte_en;
        r_wr   <= mem_wr;
        r_cnt  <= 4'(WAIT_STATES);
      end
      if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (r_state == S_ACCESS && !r_wr) r_q <= r_mem[r_addr];
    end
  end
  // Store port carries both the zero-fill sweep and lane-masked client writes.
  always_ff @(posedge clk_logic) begin
    if (!reset && r_state == S_CLEAR)
      r_mem[r_clr] <= '0;
    else if (!reset && r_state == S_ACCESS && r_wr)
      for (int i = 0; i < 4; i++)
        if (r_be[i]) r_mem[r_addr][8*i +: 8] <= r_data[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_port_bram_server.sv
// tb_mem_port_bram_server: directed vector table plus reset/handshake corner sequences.
module tb_mem_port_bram_server;
  logic        clk_logic = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [3:0]  mem_byte_en = '0;
  logic [31:0] mem_q;
  logic        mem_ready;
  logic        init_done;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_q = '0;
  logic [31:0] q;
  int          n;
  typedef struct {
    logic        wr;
    logic        rd;
    logic [20:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[13];
  mem_port_bram_server dut (
    .clk_logic(clk_logic), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_byte_en(mem_byte_en),
    .mem_q(mem_q), .mem_ready(mem_ready), .init_done(init_done)
  );
  always #5 clk_logic = ~clk_logic;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic wait_init(output int cyc);
    cyc = 0;
    while (init_done !== 1'b1 && cyc < 2000) begin
      @(negedge clk_logic);
      cyc++;
      if (mem_ready !== 1'b0) chk("ready_in_clear", 32'(mem_ready), 32'd0);
    end
    chk("init_cycles", 32'(cyc), 32'd1024);
  endtask
  task automatic txn(input logic wr, input logic rd, input logic [20:0] a, input logic [31:0] d,
                     input logic [3:0] be, input bit hold, input bit chg, output logic [31:0] rq);
    int lat;
    mem_wr = wr; mem_rd = rd; mem_addr = a; mem_data = d; mem_byte_en = be;
    lat = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_logic);
      if (chg && k == 1) begin
        mem_addr = 21'h30; mem_data = 32'h0; mem_byte_en = 4'h0;
      end
      if (mem_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    rq = mem_q;
    chk("latency", 32'(lat), 32'd4);
    if (!hold) begin mem_wr = 1'b0; mem_rd = 1'b0; end
    @(negedge clk_logic);
    chk("ready_width", 32'(mem_ready), 32'd0);
    chk("q_hold", mem_q, rq);
    @(negedge clk_logic);
    mem_wr = 1'b0; mem_rd = 1'b0;
  endtask
  initial begin
    vt[0]  = '{1'b1, 1'b0, 21'h10,  32'hDEADBEEF, 4'hF, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 21'h10,  32'h0,        4'h0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 1'b0, 21'h10,  32'h11223344, 4'h5, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 21'h10,  32'h0,        4'h0, 32'hDE22BE44};
    vt[4]  = '{1'b1, 1'b0, 21'h10,  32'hFFFFFFFF, 4'h0, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 21'h10,  32'h0,        4'h0, 32'hDE22BE44};
    vt[6]  = '{1'b1, 1'b0, 21'h400, 32'hCAFEF00D, 4'hF, 32'h0};
    vt[7]  = '{1'b0, 1'b1, 21'h0,   32'h0,        4'h0, 32'hCAFEF00D};
    vt[8]  = '{1'b1, 1'b1, 21'h30,  32'h12345678, 4'hF, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 21'h30,  32'h0,        4'h0, 32'h12345678};
    vt[10] = '{1'b0, 1'b1, 21'h7,   32'h0,        4'h0, 32'h0};
    vt[11] = '{1'b1, 1'b0, 21'h3FF, 32'hA5A5A5A5, 4'h8, 32'h0};
    vt[12] = '{1'b0, 1'b1, 21'h3FF, 32'h0,        4'h0, 32'hA5000000};
    repeat (3) @(negedge clk_logic);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_init", 32'(init_done), 32'd0);
    chk("rst_q", mem_q, 32'h0);
    mem_rd = 1'b1; mem_addr = 21'h5; reset = 1'b0;
    wait_init(n);
    txn(1'b0, 1'b1, 21'h5, 32'h0, 4'h0, 1'b0, 1'b0, q);
    chk("rd_after_clear", q, 32'h0);
    last_q = q;
    for (int i = 0; i < 13; i++) begin
      txn(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].data, vt[i].be, 1'b0, 1'b0, q);
      if (vt[i].rd && !vt[i].wr) begin
        chk($sformatf("vec%0d_read", i), q, vt[i].exp);
        last_q = vt[i].exp;
      end else
        chk($sformatf("vec%0d_wr_q", i), q, last_q);
    end
    txn(1'b0, 1'b1, 21'h10, 32'h0, 4'h0, 1'b1, 1'b0, q);
    chk("hold_read", q, 32'hDE22BE44);
    n = 0;
    repeat (8) begin
      @(negedge clk_logic);
      if (mem_ready === 1'b1) n++;
    end
    chk("extra_ready", 32'(n), 32'd0);
    txn(1'b0, 1'b1, 21'h10, 32'h0, 4'h0, 1'b0, 1'b1, q);
    chk("addr_chg_read", q, 32'hDE22BE44);
    txn(1'b1, 1'b0, 21'h40, 32'h77777777, 4'hF, 1'b0, 1'b1, q);
    chk("chg_wr_q", q, 32'hDE22BE44);
    txn(1'b0, 1'b1, 21'h40, 32'h0, 4'h0, 1'b0, 1'b0, q);
    chk("chg_wr_read40", q, 32'h77777777);
    txn(1'b0, 1'b1, 21'h30, 32'h0, 4'h0, 1'b0, 1'b0, q);
    chk("chg_wr_read30", q, 32'h12345678);
    mem_wr = 1'b1; mem_addr = 21'h20; mem_data = 32'h55AA55AA; mem_byte_en = 4'hF;
    @(negedge clk_logic);
    reset = 1'b1;
    @(negedge clk_logic);
    chk("wait_rst_ready", 32'(mem_ready), 32'd0);
    chk("wait_rst_init", 32'(init_done), 32'd0);
    chk("wait_rst_q", mem_q, 32'h0);
    reset = 1'b0; mem_wr = 1'b0;
    n = 0;
    repeat (300) begin
      @(negedge clk_logic);
      if (mem_ready === 1'b1 || init_done === 1'b1) n++;
    end
    chk("mid_clear_quiet", 32'(n), 32'd0);
    reset = 1'b1;
    @(negedge clk_logic);
    reset = 1'b0;
    wait_init(n);
    txn(1'b0, 1'b1, 21'h20, 32'h0, 4'h0, 1'b0, 1'b0, q);
    chk("aborted_wr_read", q, 32'h0);
    txn(1'b0, 1'b1, 21'h10, 32'h0, 4'h0, 1'b0, 1'b0, q);
    chk("reclear_read", q, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
